muldiv_sequencer: RTL and testbench

//  Iterative RV32M multiply/divide unit with its own control FSM. Sits beside the main ALU.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_iter_step.sv | 41 ++++
 rtl/muldiv_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned DefaultXlen = 32;
  localparam int unsigned DefaultCntW = 6;

  // RV32M funct3 encodings
  localparam logic [2:0] OpMul    = 3'd0;
  localparam logic [2:0] OpMulh   = 3'd1;
  localparam logic [2:0] OpMulhsu = 3'd2;
  localparam logic [2:0] OpMulhu  = 3'd3;
  localparam logic [2:0] OpDiv    = 3'd4;
  localparam logic [2:0] OpDivu   = 3'd5;
  localparam logic [2:0] OpRem    = 3'd6;
  localparam logic [2:0] OpRemu   = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } state_e;

endpackage

// File: rtl/muldiv_iter_step.sv
// One radix-2 iteration on {acc, shreg}: shift-add for multiply, restoring subtract for divide.
module muldiv_iter_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] acc_i,
  input  logic [XLEN-1:0] shreg_i,
  input  logic [XLEN-1:0] operand_i,
  output logic [XLEN-1:0] acc_o,
  output logic [XLEN-1:0] shreg_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] trial;
  logic [XLEN:0] diff;

  always_comb begin
    sum     = '0;
    trial   = '0;
    diff    = '0;
    acc_o   = acc_i;
    shreg_o = shreg_i;
    if (is_div_i) begin
      // acc < divisor always holds, so diff[XLEN] is a clean borrow flag
      trial = {acc_i, shreg_i[XLEN-1]};
      diff  = trial - {1'b0, operand_i};
      if (!diff[XLEN]) begin
        acc_o   = diff[XLEN-1:0];
        shreg_o = {shreg_i[XLEN-2:0], 1'b1};
      end else begin
        acc_o   = trial[XLEN-1:0];
        shreg_o = {shreg_i[XLEN-2:0], 1'b0};
      end
    end else begin
      sum     = {1'b0, acc_i} + (shreg_i[0] ? {1'b0, operand_i} : '0);
      acc_o   = sum[XLEN:1];
      shreg_o = {sum[0], shreg_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit with valid/ready request and response handshakes.
// Optional MULDIV_EARLY_OUT_EN: multiplies finish early once remaining multiplier bits are zero.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = DefaultXlen,
  parameter int unsigned CNT_W = DefaultCntW
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_addr_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o,
  output logic            stall_o
);

  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]      op_q;
  logic            neg_q;
  logic [XLEN-1:0] operand_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] shreg_q;

  logic            is_div_in;
  logic            a_signed;
  logic            b_signed;
  logic            sa;
  logic            sb;
  logic            neg_in;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] fast_result;

  logic [XLEN-1:0]   acc_step;
  logic [XLEN-1:0]   shreg_step;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fixed;
  logic [XLEN-1:0]   div_field;
  logic [XLEN-1:0]   fix_result;

  assign req_ready_o = (state_q == StIdle) && start_i;

  always_comb begin
    is_div_in = op_i[2];
    a_signed  = (op_i == OpMulh) || (op_i == OpMulhsu) || (op_i == OpDiv) || (op_i == OpRem);
    b_signed  = (op_i == OpMulh) || (op_i == OpDiv) || (op_i == OpRem);
    sa        = a_signed && rs1_i[XLEN-1];
    sb        = b_signed && rs2_i[XLEN-1];
    a_mag     = sa ? (~rs1_i + 1'b1) : rs1_i;
    b_mag     = sb ? (~rs2_i + 1'b1) : rs2_i;
    // Remainder takes the dividend's sign; everything else takes sign(A)^sign(B)
    neg_in    = (op_i == OpRem) ? sa : (sa ^ sb);
    div_zero  = is_div_in && (rs2_i == '0);
    div_ovf   = ((op_i == OpDiv) || (op_i == OpRem)) && (rs1_i == MinNeg) && (rs2_i == '1);
    if (div_zero) begin
      fast_result = op_i[1] ? rs1_i : '1;
    end else begin
      fast_result = op_i[1] ? '0 : MinNeg;
    end
  end

  muldiv_iter_step #(
    .XLEN(XLEN)
  ) u_step (
    .is_div_i (op_q[2]),
    .acc_i    (acc_q),
    .shreg_i  (shreg_q),
    .operand_i(operand_q),
    .acc_o    (acc_step),
    .shreg_o  (shreg_step)
  );

  always_comb begin
    prod       = {acc_q, shreg_q};
    prod_fixed = neg_q ? (~prod + 1'b1) : prod;
    div_field  = op_q[1] ? acc_q : shreg_q;
    if (op_q[2]) begin
      fix_result = neg_q ? (~div_field + 1'b1) : div_field;
    end else if (op_q == OpMul) begin
      fix_result = prod_fixed[XLEN-1:0];
    end else begin
      fix_result = prod_fixed[2*XLEN-1:XLEN];
    end
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic [XLEN-1:0]   rem_mask;
  logic [2*XLEN-1:0] prod_early;

  // Bits [XLEN-1-cnt:0] of shreg are the multiplier bits not yet consumed
  assign rem_mask   = {XLEN{1'b1}} >> cnt_q;
  assign prod_early = prod >> ((CNT_W+1)'(XLEN) - {1'b0, cnt_q});
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      op_q         <= '0;
      neg_q        <= 1'b0;
      operand_q    <= '0;
      acc_q        <= '0;
      shreg_q      <= '0;
      resp_valid_o <= 1'b0;
      result_o     <= '0;
      rd_addr_o    <= '0;
      stall_o      <= 1'b0;
    end else if (flush_i) begin
      state_q      <= StIdle;
      resp_valid_o <= 1'b0;
      stall_o      <= 1'b0;
    end else if (start_i) begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            op_q      <= op_i;
            rd_addr_o <= rd_addr_i;
            neg_q     <= neg_in;
            operand_q <= is_div_in ? b_mag : a_mag;
            shreg_q   <= is_div_in ? a_mag : b_mag;
            acc_q     <= '0;
            cnt_q     <= '0;
            stall_o   <= 1'b1;
            if (div_zero || div_ovf) begin
              state_q      <= StDone;
              result_o     <= fast_result;
              resp_valid_o <= 1'b1;
            end else begin
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
`ifdef MULDIV_EARLY_OUT_EN
          if (!op_q[2] && ((shreg_q & rem_mask) == '0)) begin
            {acc_q, shreg_q} <= prod_early;
            state_q          <= StFix;
          end else
`endif
          begin
            acc_q   <= acc_step;
            shreg_q <= shreg_step;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(XLEN - 1)) begin
              state_q <= StFix;
            end
          end
        end
        StFix: begin
          result_o     <= fix_result;
          resp_valid_o <= 1'b1;
          state_q      <= StDone;
        end
        StDone: begin
          if (resp_ready_i) begin
            state_q      <= StIdle;
            resp_valid_o <= 1'b0;
            stall_o      <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer (default build, fixed latency).
module tb_muldiv_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [4:0]  rd_in;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        stall;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .start_i     (start),
    .flush_i     (flush),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .op_i        (op),
    .rs1_i       (rs1),
    .rs2_i       (rs2),
    .rd_addr_i   (rd_in),
    .resp_valid_o(resp_valid),
    .resp_ready_i(resp_ready),
    .result_o    (result),
    .rd_addr_o   (rd_out),
    .stall_o     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one op, waits (bounded) for the response; lat counts cycles after the accept edge.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                        output int lat, output int stall_gaps);
    op = o; rs1 = a; rs2 = b; rd_in = rd; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    stall_gaps = 0;
    while (!resp_valid && lat < 200) begin
      if (!stall) stall_gaps++;
      @(posedge clk); #1;
      lat++;
    end
    if (!stall) stall_gaps++;
    res = result;
    rdo = rd_out;
    if (resp_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    op = '0; rs1 = '0; rs2 = '0; rd_in = '0;
    #12;
    checks++;
    if (resp_valid !== 1'b0 || stall !== 1'b0 || result !== 32'h0 || rd_out !== 5'h0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b stall=%b result=%h rd=%h, want all 0",
               resp_valid, stall, result, rd_out);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_start1: got %b want 1", req_ready);
    end
    start = 1'b0; #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_start0: got %b want 0", req_ready);
    end
    start = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    logic [31:0] res;
    logic [4:0]  rdo;
    int          lat;
    int          gaps;
    run_op(3'd0, 32'd7, 32'd6, 5'd3, res, rdo, lat, gaps);
    checks++;
    if (res !== 32'd42) begin errors++; $display("FAIL mul_7x6: got %h want %h", res, 32'd42); end
    checks++;
    if (lat !== 34) begin errors++; $display("FAIL mul_latency: got %0d want 34", lat); end
    checks++;
    if (gaps !== 0) begin errors++; $display("FAIL mul_stall: %0d low cycles, want 0", gaps); end
    checks++;
    if (rdo !== 5'd3) begin errors++; $display("FAIL mul_rd: got %0d want 3", rdo); end
    checks++;
    if (req_ready !== 1'b1 || stall !== 1'b0) begin
      errors++;
      $display("FAIL mul_idle_after: got ready=%b stall=%b want 1/0", req_ready, stall);
    end
    run_op(3'd0, 32'hFFFFFFFD, 32'd5, 5'd4, res, rdo, lat, gaps);
    checks++;
    if (res !== 32'hFFFFFFF1) begin
      errors++; $display("FAIL mul_neg3x5: got %h want fffffff1", res);
    end
  endtask

  task automatic test_mulh();
    logic [31:0] res;
    logic [4:0]  rdo;
    int          lat;
    int          gaps;
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, res, rdo, lat, gaps);
    checks++;
    if (res !== 32'hFFFFFFFE) begin errors++; $display("FAIL mulhu: got %h want fffffffe", res); end
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, res, rdo, lat, gaps);
    checks++;
    if (res !== 32'h0) begin errors++; $display("FAIL mulh_m1m1: got %h want 0", res); end
    run_op(3'd2, 32'hFFFFFFFF, 32'd2, 5'd7, res, rdo, lat, gaps);
    checks++;
    if (res !== 32'hFFFFFFFF) begin errors++; $display("FAIL mulhsu: got %h want ffffffff", res); end
  endtask

  task automatic test_div();
    logic [31:0] res;
    logic [4:0]  rdo;
    int          lat;
    int          gaps;
    run_op(3'd4, 32'hFFFFFFF9, 32'd2, 5'd8, res, rdo, lat, gaps);
    checks++;
    if (res !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_m7_2: got %h want fffffffd", res); end
    checks++;
    if (lat !== 34) begin errors++; $display("FAIL div_latency: got %0d want 34", lat); end
    run_op(3'd6, 32'hFFFFFFF9, 32'd2, 5'd8, res, rdo, lat, gaps);
    checks++;
    if (res !== 32'hFFFFFFFF) begin errors++; $display("FAIL rem_m7_2: got %h want ffffffff", res); end
    run_op(3'd5, 32'd100, 32'd7, 5'd8, res, rdo, lat, gaps);
    checks++;
    if (res !== 32'd14) begin errors++; $display("FAIL divu_100_7: got %0d want 14", res); end
    run_op(3'd7, 32'd100, 32'd7, 5'd8, res, rdo, lat, gaps);
    checks++;
    if (res !== 32'd2) begin errors++; $display("FAIL remu_100_7: got %0d want 2", res); end
  endtask

  task automatic test_fast_path();
    logic [31:0] res;
    logic [4:0]  rdo;
    int          lat;
    int          gaps;
    run_op(3'd5, 32'd5, 32'd0, 5'd10, res, rdo, lat, gaps);
    checks++;
    if (res !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu_by0: got %h want ffffffff", res); end
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL divu_by0_latency: got %0d want 1", lat); end
    run_op(3'd6, 32'd5, 32'd0, 5'd11, res, rdo, lat, gaps);
    checks++;
    if (res !== 32'd5) begin errors++; $display("FAIL rem_by0: got %h want 5", res); end
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd12, res, rdo, lat, gaps);
    checks++;
    if (res !== 32'h80000000) begin errors++; $display("FAIL div_ovf: got %h want 80000000", res); end
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL div_ovf_latency: got %0d want 1", lat); end
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd13, res, rdo, lat, gaps);
    checks++;
    if (res !== 32'h0) begin errors++; $display("FAIL rem_ovf: got %h want 0", res); end
  endtask

  task automatic test_flush();
    int seen;
    op = 3'd0; rs1 = 32'd9; rs2 = 32'd9; rd_in = 5'd14; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    checks++;
    if (stall !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_pre: got stall=%b valid=%b want 1/0", stall, resp_valid);
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: got ready=%b stall=%b want 1/0", req_ready, stall);
    end
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL flush_no_resp: got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_backpressure();
    logic [31:0] res;
    logic [4:0]  rdo;
    int          lat;
    int          gaps;
    resp_ready = 1'b0;
    run_op(3'd5, 32'd100, 32'd7, 5'd21, res, rdo, lat, gaps);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || result !== 32'd14 || rd_out !== 5'd21 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: got valid=%b result=%h rd=%0d ready=%b want 1/0000000e/21/0",
                 i, resp_valid, result, rd_out, req_ready);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: got valid=%b ready=%b want 0/1", resp_valid, req_ready);
    end
  endtask

  task automatic test_start_low();
    int lat;
    op = 3'd0; rs1 = 32'd7; rs2 = 32'd6; rd_in = 5'd17; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    repeat (4) begin @(posedge clk); #1; lat++; end
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; lat++; end
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL freeze_stall: got %b want 1", stall); end
    start = 1'b1;
    while (!resp_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat !== 39 || result !== 32'd42) begin
      errors++;
      $display("FAIL freeze_latency: got lat=%0d result=%h want 39/0000002a", lat, result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    int seen;
    op = 3'd5; rs1 = 32'd50; rs2 = 32'd3; rd_in = 5'd25; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || stall !== 1'b0 || result !== 32'h0 || rd_out !== 5'h0 ||
        req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midop_reset: got valid=%b stall=%b result=%h rd=%h ready=%b want 0/0/0/0/1",
               resp_valid, stall, result, rd_out, req_ready);
    end
    #2;
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL midop_no_resp: got %0d valid cycles want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_fast_path();
    test_flush();
    test_backpressure();
    test_start_low();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
